wb_c_uart: RTL
==============

Name: wb_c_uart

Overview:
- Wishbone slave hung on the byte-wide wb_c port of the CPU bus interface unit; claims CPU region 0xC000_0000.
- Provides a buffered 8N1 UART: TX FIFO, RX FIFO, status register, level interrupt.
- Consumes the BIU's wb_c_stb/we/adr/dat and returns dat/ack/err/rty, which the BIU turns into Cpu_ready_o and Cpu_data4bus_o.

Parameters:
CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
FIFO_DEPTH, 16, entries per FIFO; power of two, 2..256.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset.
wb_c_stb_i  in  1  strobe; held by the BIU until the transaction is acknowledged.
wb_c_we_i  in  1  1 = write.
wb_c_adr_i  in  32  byte address; only [3:2] decoded.
wb_c_dat_i  in  8  write data.
wb_c_dat_o  out  8  read data; valid while wb_c_ack_o is high.
wb_c_ack_o  out  1  transaction completed.
wb_c_err_o  out  1  transaction rejected.
wb_c_rty_o  out  1  retry; tied 0.
uart_txd  out  1  serial out; idle high.
uart_rxd  in  1  serial in; asynchronous.
irq_o  out  1  level interrupt.

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous and active-low.
- Reset values: wb_c_dat_o=0, wb_c_ack_o=0, wb_c_err_o=0, uart_txd=1, irq_o=0.
- Both FIFOs empty, all flags 0, both FSMs in IDLE.

Register map (adr[3:2]):
- 0 DATA: write pushes TX FIFO; read pops RX FIFO.
- 1 STATUS (read only): bit0 rx_valid, bit1 tx_full, bit2 tx_idle (FIFO empty and TX FSM idle), bit3 rx_overrun, bit4 frame_err, bits7:5 = 0.
- 2 CTRL: bit0 loopback (see Optional Feature); bit1 irq_en. Read back as written.
- 3 CLEAR: write 1 to bit2 clears rx_overrun; write 1 to bit3 clears frame_err. Reads 0.

Bus FSM:
- States BIDLE -> BRESP -> BWAIT.
- BIDLE: on stb=1, go to BRESP.
- BRESP: exactly one cycle of ack or err, plus the side effect (push, pop or register write). Latency is 1 cycle from stb to response.
- BWAIT: hold until stb=0, then return to BIDLE. One side effect per strobe even if stb is held.
- err cases: DATA write while TX FIFO full (byte dropped); DATA read while RX FIFO empty (dat_o=0).
- Otherwise ack.

TX FSM:
- States TIDLE, TSTART, TDATA, TSTOP; each bit lasts CLK_DIV cycles.
- TIDLE: if TX FIFO non-empty, pop and go to TSTART (txd=0).
- TDATA: sends 8 bits, LSB first.
- TSTOP: txd=1, then back to TIDLE. Back-to-back frames have no extra idle gap.

RX path:
- uart_rxd goes through a 2-flop synchronizer.
- States RIDLE, RSTART, RDATA, RSTOP.
- A falling edge in RIDLE goes to RSTART. Sample at CLK_DIV/2; if high, treat as a glitch and return to RIDLE.
- Data bits are sampled at bit centres.
- RSTOP with sample 0: set frame_err and discard the byte.
- Otherwise push the byte. If the RX FIFO is full, set rx_overrun and drop the new byte (FIFO contents kept).

Simultaneous events and FIFOs:
- CPU pop and RX push in the same cycle: both take effect, count unchanged.
- CPU push and TX pop in the same cycle: both take effect, count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- A count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.

Interrupt:
- irq_o = irq_en & (rx_valid | rx_overrun | frame_err), registered.

Reset mid-operation:
- A frame in flight is aborted and txd is forced high immediately.
- Any pending ack is cancelled.

Optional Feature:
Macro UART_LOOPBACK_EN.
- Defined: CTRL bit0=1 feeds internal txd into the RX path in place of the synchronized uart_rxd; pin uart_txd stays at 1.
- Not defined: CTRL bit0 is hardwired to 0 (writes ignored, reads 0), and no loopback mux is built.

Test Plan:
- Reset with CLK_DIV=4 -> txd=1, STATUS reads 0x04, irq_o=0; read DATA -> err=1, dat_o=0x00.
- Write DATA 0xA5 -> ack 1 cycle after stb; txd shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; STATUS.tx_idle returns to 1 after the stop bit.
- Write 17 bytes with FIFO_DEPTH=16 while TX is busy -> the first 16 are acked, the 17th gets err; STATUS.tx_full=1 before the 17th; exactly 16 frames are emitted.
- Drive 0x3C on uart_rxd with a correct stop bit and irq_en=1 -> rx_valid=1, irq_o=1; read DATA -> 0x3C with ack; irq_o falls.
- Send 17 frames into an undrained FIFO, then one frame with stop bit 0 -> rx_overrun=1, frame_err=1; write CLEAR 0x0C -> both flags 0; 16 bytes still readable in order.
- With UART_LOOPBACK_EN defined: set CTRL 0x01, write 0x5A -> uart_txd pin stays 1 and a DATA read returns 0x5A. Without the macro: CTRL reads 0x00 after writing 0x01.

Source files
------------

// File: rtl/wb_c_uart.sv
// wb_c_uart: byte-wide Wishbone slave with a buffered 8N1 UART, TX/RX FIFOs and level irq.
// Optional feature: define UART_LOOPBACK_EN to build the internal TX->RX loopback (CTRL bit0).
module wb_c_uart #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_c_stb_i,
  input  logic        wb_c_we_i,
  input  logic [31:0] wb_c_adr_i,
  input  logic [7:0]  wb_c_dat_i,
  output logic [7:0]  wb_c_dat_o,
  output logic        wb_c_ack_o,
  output logic        wb_c_err_o,
  output logic        wb_c_rty_o,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full    = CntW'(FIFO_DEPTH);
  localparam logic [15:0]     BitEnd  = 16'(CLK_DIV - 1);
  localparam logic [15:0]     HalfEnd = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {BIdle, BResp, BWait} bus_state_e;
  typedef enum logic [1:0] {TIdle, TStart, TData, TStop} tx_state_e;
  typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;

  bus_state_e bus_state;
  tx_state_e  tx_state;
  rx_state_e  rx_state;

  // FIFO storage and bookkeeping
  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CntW-1:0] tx_count, rx_count;
  logic            tx_push, tx_pop, rx_push, rx_pop;
  logic            tx_full, tx_empty, rx_full, rx_empty;

  // Bus side
  logic [1:0] reg_sel;
  logic       bus_go, bus_err;
  logic [7:0] rdata;
  logic       irq_en, ctrl_loop;
  logic       clr_overrun, clr_frame;
  logic       ack_q, err_q, irq_q;
  logic [7:0] dat_q;

  // Serial side
  logic        tx_line;
  logic [15:0] tx_cnt, rx_cnt;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_shift, rx_shift;
  logic        rx_meta, rx_sync, rx_in, rx_prev;
  logic        rx_overrun, frame_err;
  logic        tx_idle, rx_valid;

  logic unused_adr;
  assign unused_adr = ^{wb_c_adr_i[31:4], wb_c_adr_i[1:0]};

  assign reg_sel  = wb_c_adr_i[3:2];
  assign tx_full  = (tx_count == Full);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == Full);
  assign rx_empty = (rx_count == '0);
  assign rx_valid = !rx_empty;
  assign tx_idle  = tx_empty && (tx_state == TIdle);

  assign bus_go  = (bus_state == BIdle) && wb_c_stb_i;
  assign bus_err = (reg_sel == 2'd0) && (wb_c_we_i ? tx_full : rx_empty);
  assign tx_push = bus_go && wb_c_we_i && (reg_sel == 2'd0) && !tx_full;
  assign rx_pop  = bus_go && !wb_c_we_i && (reg_sel == 2'd0) && !rx_empty;
  assign clr_overrun = bus_go && wb_c_we_i && (reg_sel == 2'd3) && wb_c_dat_i[2];
  assign clr_frame   = bus_go && wb_c_we_i && (reg_sel == 2'd3) && wb_c_dat_i[3];

  // TX reloads straight out of the stop bit so back-to-back frames have no idle gap.
  assign tx_pop  = !tx_empty &&
                   ((tx_state == TIdle) || ((tx_state == TStop) && (tx_cnt == BitEnd)));
  assign rx_push = (rx_state == RStop) && (rx_cnt == BitEnd) && rx_in && !rx_full;

`ifdef UART_LOOPBACK_EN
  assign rx_in    = ctrl_loop ? tx_line : rx_sync;
  assign uart_txd = ctrl_loop ? 1'b1 : tx_line;
`else
  assign ctrl_loop = 1'b0;
  assign rx_in     = rx_sync;
  assign uart_txd  = tx_line;
`endif

  always_comb begin
    rdata = 8'h00;
    case (reg_sel)
      2'd0: rdata = rx_empty ? 8'h00 : rx_mem[rx_rd];
      2'd1: rdata = {3'b000, frame_err, rx_overrun, tx_idle, tx_full, rx_valid};
      2'd2: rdata = {6'b000000, irq_en, ctrl_loop};
      2'd3: rdata = 8'h00;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= wb_c_dat_i;
    if (rx_push) rx_mem[rx_wr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // Bus FSM: one registered response and one side effect per strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_state <= BIdle;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= 8'h00;
      irq_en    <= 1'b0;
`ifdef UART_LOOPBACK_EN
      ctrl_loop <= 1'b0;
`endif
    end else begin
      case (bus_state)
        BIdle: begin
          if (wb_c_stb_i) begin
            bus_state <= BResp;
            ack_q     <= !bus_err;
            err_q     <= bus_err;
            dat_q     <= (wb_c_we_i || bus_err) ? 8'h00 : rdata;
            if (wb_c_we_i && (reg_sel == 2'd2)) begin
              irq_en <= wb_c_dat_i[1];
`ifdef UART_LOOPBACK_EN
              ctrl_loop <= wb_c_dat_i[0];
`endif
            end
          end
        end
        BResp: begin
          ack_q     <= 1'b0;
          err_q     <= 1'b0;
          dat_q     <= 8'h00;
          bus_state <= wb_c_stb_i ? BWait : BIdle;
        end
        BWait: begin
          if (!wb_c_stb_i) bus_state <= BIdle;
        end
        default: bus_state <= BIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TIdle;
      tx_line  <= 1'b1;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
    end else begin
      case (tx_state)
        TIdle: begin
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd];
            tx_line  <= 1'b0;
            tx_cnt   <= 16'd0;
            tx_state <= TStart;
          end
        end
        TStart: begin
          if (tx_cnt == BitEnd) begin
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_line  <= tx_shift[0];
            tx_state <= TData;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TData: begin
          if (tx_cnt == BitEnd) begin
            tx_cnt <= 16'd0;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= TStop;
            end else begin
              tx_line  <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TStop: begin
          if (tx_cnt == BitEnd) begin
            tx_cnt <= 16'd0;
            if (tx_pop) begin
              tx_shift <= tx_mem[tx_rd];
              tx_line  <= 1'b0;
              tx_state <= TStart;
            end else begin
              tx_state <= TIdle;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
    end
  end

  // RX FSM; a flag set in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RIdle;
      rx_cnt     <= 16'd0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'h00;
      rx_prev    <= 1'b1;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_prev <= rx_in;
      if (clr_overrun) rx_overrun <= 1'b0;
      if (clr_frame)   frame_err  <= 1'b0;
      case (rx_state)
        RIdle: begin
          if (rx_prev && !rx_in) begin
            rx_cnt   <= 16'd0;
            rx_state <= RStart;
          end
        end
        RStart: begin
          if (rx_cnt == HalfEnd) begin
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_state <= rx_in ? RIdle : RData;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RData: begin
          if (rx_cnt == BitEnd) begin
            rx_cnt   <= 16'd0;
            rx_shift <= {rx_in, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RStop;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RStop: begin
          if (rx_cnt == BitEnd) begin
            rx_cnt   <= 16'd0;
            rx_state <= RIdle;
            if (!rx_in)       frame_err  <= 1'b1;
            else if (rx_full) rx_overrun <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_state <= RIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= irq_en && (rx_valid || rx_overrun || frame_err);
  end

  assign wb_c_dat_o = dat_q;
  assign wb_c_ack_o = ack_q;
  assign wb_c_err_o = err_q;
  assign wb_c_rty_o = 1'b0;
  assign irq_o      = irq_q;

endmodule
